urna_terminal: RTL
==================

// Module: urna_terminal
// PURPOSE
//  Voter-side keypad terminal. Drives the ballot box's Digit/Valid vote interface
//  and reads back its VoteStatus. A poll worker releases the terminal for one voter.
//  The voter keys one candidate code, may correct it, then confirms.
//  The terminal then emits a single one-cycle vote, captures the accept/null result,
//  and locks again. An idle voter is forced into a null vote by a timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  1000  cycles allowed in WAIT_KEY+WAIT_CONFIRM before a forced null vote
//  TIMER_W         10    timer width; must satisfy 2**TIMER_W > TIMEOUT_CYCLES
// PORTS
//  Clock      in   1  single clock, all logic on posedge
//  Reset      in   1  synchronous, active-high
//  Enable     in   1  poll-worker release pulse; honoured only in LOCKED
//  Key        in   4  keypad code, sampled when KeyStrobe=1
//  KeyStrobe  in   1  one-cycle key press qualifier
//  Confirm    in   1  one-cycle "CONFIRMA" press
//  Correct    in   1  one-cycle "CORRIGE" press
//  VoteStatus in   1  ballot-box result: 1 = counted for a candidate, 0 = null
//  Digit      out  4  vote code to ballot box; 4'b0000 whenever Valid=0
//  Valid      out  1  one-cycle vote strobe
//  Ready      out  1  1 in WAIT_KEY/WAIT_CONFIRM (terminal released to voter)
//  Pending    out  1  1 in WAIT_CONFIRM (a code is latched, awaiting confirm)
//  Shown      out  4  latched code for display; 0 when not Pending
//  Done       out  1  one-cycle pulse: vote finished, Accepted is updated
//  Accepted   out  1  VoteStatus captured for the last vote; held until the next Done
//  VotesCast  out  8  number of completed votes; saturates at 8'hFF
// BEHAVIOUR
//  Reset: state=LOCKED, timer=0; every output is 0.
//  All outputs are registered. Reset wins over every other input in the same cycle.
//  States: LOCKED, WAIT_KEY, WAIT_CONFIRM, EMIT, ACK.
//  LOCKED: Enable=1 -> WAIT_KEY and timer cleared. Keys, Confirm and Correct are ignored.
//  WAIT_KEY: KeyStrobe=1 latches Key into the code register -> WAIT_CONFIRM.
//    Confirm or Correct without a latched code is ignored.
//  WAIT_CONFIRM:
//    Correct=1 -> code cleared, -> WAIT_KEY, timer cleared.
//    Confirm=1 -> EMIT.
//    Correct and Confirm in the same cycle: Correct wins.
//    KeyStrobe is ignored; the code is single-digit and is changed only via Correct.
//  Timer: increments each cycle in WAIT_KEY and WAIT_CONFIRM.
//    When it reaches TIMEOUT_CYCLES-1, the next state is EMIT with code forced to 4'b0000 (null vote).
//    Confirm in that same cycle still emits the latched code; timeout only overrides when there is no confirm.
//  EMIT: exactly one cycle. Valid=1 and Digit=code -> ACK.
//    Any code value is passed through unfiltered; the ballot box decides validity.
//  ACK: one cycle; VoteStatus is sampled at the end of this cycle.
//    Next cycle: Accepted<=VoteStatus, Done=1, VotesCast+1 (held at 255), state LOCKED.
//  Latency: Confirm in cycle N -> Valid in N+1 -> VoteStatus sampled end of N+2 -> Done in N+3.
//  Enable received outside LOCKED is ignored; it is not queued.
//  Reset during EMIT/ACK aborts the vote: no Done, VotesCast cleared.
//  Ready, Pending and Shown are 0 in EMIT and ACK, so keypad input is locked out in those states.
// STRUCTURE
//  Shared package urna_pkg holds:
//    - state enum: LOCKED, WAIT_KEY, WAIT_CONFIRM, EMIT, ACK
//    - code constants: CAND1=4'd1, CAND2=4'd5, CAND3=4'd6, CAND4=4'd8, NULL_CODE=4'd0
//    - VOTE_W=8 (counter width, shared with the ballot box)
//  One sub-module, urna_timeout_timer (clear, run -> expired), parameterised by
//  TIMEOUT_CYCLES and TIMER_W. FSM, code register and outputs stay in this module.
// TESTING
//  1. Reset -> all outputs 0.
//     Enable, Key=5+strobe, Confirm@N -> Valid=1,Digit=5 only at N+1.
//     VoteStatus=1 at N+2 -> Done@N+3, Accepted=1, VotesCast=1.
//  2. Key=1, Correct, Key=8, Confirm -> single Valid with Digit=8; Digit=0 on all other cycles.
//  3. Key=6, then Correct and Confirm in the same cycle -> back to WAIT_KEY, no Valid.
//  4. Enable with no keys, TIMEOUT_CYCLES=16 -> Valid with Digit=0 exactly 16 cycles after release.
//     VoteStatus=0 -> Accepted=0.
//  5. Confirm/KeyStrobe while LOCKED and Enable during WAIT_KEY -> no effect.
//     257 completed votes -> VotesCast=255.
//  6. Reset asserted in the EMIT cycle -> next cycle LOCKED, Valid=0, no Done, VotesCast=0.

Source files
------------

// File: rtl/urna_pkg.sv
// Shared definitions for the voting terminal and the ballot box it talks to.
//   state_t   : terminal FSM states
//   CANDx     : candidate codes as keyed on the keypad; NULL_CODE is the null vote
//   VOTE_W    : vote counter width, shared with the ballot box
//   sat_inc   : saturating increment for the vote counter
package urna_pkg;

    typedef enum logic [2:0] {
        LOCKED,
        WAIT_KEY,
        WAIT_CONFIRM,
        EMIT,
        ACK
    } state_t;

    localparam logic [3:0] CAND1     = 4'd1;
    localparam logic [3:0] CAND2     = 4'd5;
    localparam logic [3:0] CAND3     = 4'd6;
    localparam logic [3:0] CAND4     = 4'd8;
    localparam logic [3:0] NULL_CODE = 4'd0;

    localparam int VOTE_W = 8;

    function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/urna_terminal_if.sv
// Vote bus between terminal (master) and ballot box (slave).
//   digit       : vote code, 0 whenever valid is low
//   valid       : one-cycle vote strobe
//   vote_status : ballot-box verdict, 1 = counted for a candidate, 0 = null
interface urna_terminal_if;
    logic [3:0] digit;
    logic       valid;
    logic       vote_status;

    modport master (output digit, output valid, input vote_status);
    modport slave  (input digit, input valid, output vote_status);
endinterface

// File: rtl/urna_timeout_timer.sv
// Idle-voter timer. Counts while i_run is high; o_expired flags the last allowed
// cycle (count == TIMEOUT_CYCLES-1) so the FSM can force a null vote.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : zero the count (takes priority over i_run)
//   i_run        : count this cycle
//   o_expired    : running and on the final allowed cycle
module urna_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [TIMER_W-1:0] r_cnt;

    assign o_expired = i_run && (r_cnt == TIMER_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear)
            r_cnt <= '0;
        else if (i_run && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/urna_terminal.sv
// Voter-side keypad terminal. A poll worker releases it with i_enable; the voter
// keys one code, may correct it, and confirms. One vote is strobed onto the vote
// bus, the ballot-box verdict is captured, and the terminal locks again. An idle
// voter is forced into a null vote after TIMEOUT_CYCLES.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_enable       : release pulse, honoured only while locked
//   i_key/i_key_strobe, i_confirm, i_correct : keypad
//   vote_bus       : digit/valid out, vote_status in
//   o_ready        : released to the voter
//   o_pending      : a code is latched awaiting confirm; o_shown displays it
//   o_done         : one-cycle vote-finished pulse; o_accepted holds the verdict
//   o_votes_cast   : completed votes, saturating
// Every output is a register loaded from the next-state/next-code values, so
// outputs line up with the state they describe without a combinational path out.
module urna_terminal
    import urna_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [3:0]        i_key,
    input  logic              i_key_strobe,
    input  logic              i_confirm,
    input  logic              i_correct,
    urna_terminal_if.master   vote_bus,
    output logic              o_ready,
    output logic              o_pending,
    output logic [3:0]        o_shown,
    output logic              o_done,
    output logic              o_accepted,
    output logic [VOTE_W-1:0] o_votes_cast
);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_code, w_code_nxt;
    logic                w_expired, w_timer_clr, w_timer_run;

    logic [3:0]          r_digit, w_digit;
    logic                r_valid, w_valid;
    logic                r_ready, w_ready;
    logic                r_pending, w_pending;
    logic [3:0]          r_shown, w_shown;
    logic                r_done, w_done;
    logic                r_accepted, w_accepted;
    logic [VOTE_W-1:0]   r_votes, w_votes;

    assign w_timer_run = (r_state == WAIT_KEY) || (r_state == WAIT_CONFIRM);
    // Clear on every entry into WAIT_KEY: release by the poll worker or a correction.
    assign w_timer_clr = (r_state != WAIT_KEY) && (w_state_nxt == WAIT_KEY);

    urna_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMER_W       (TIMER_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_timer_clr),
        .i_run    (w_timer_run),
        .o_expired(w_expired)
    );

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= LOCKED;
            r_code     <= NULL_CODE;
            r_digit    <= '0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_pending  <= 1'b0;
            r_shown    <= '0;
            r_done     <= 1'b0;
            r_accepted <= 1'b0;
            r_votes    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_digit    <= w_digit;
            r_valid    <= w_valid;
            r_ready    <= w_ready;
            r_pending  <= w_pending;
            r_shown    <= w_shown;
            r_done     <= w_done;
            r_accepted <= w_accepted;
            r_votes    <= w_votes;
        end
    end

    // Next state and code.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            LOCKED: begin
                w_code_nxt = NULL_CODE;
                if (i_enable) w_state_nxt = WAIT_KEY;
            end
            WAIT_KEY: begin
                // Timeout beats a key arriving on the last allowed cycle.
                if (w_expired) begin
                    w_state_nxt = EMIT;
                    w_code_nxt  = NULL_CODE;
                end else if (i_key_strobe) begin
                    w_state_nxt = WAIT_CONFIRM;
                    w_code_nxt  = i_key;
                end
            end
            WAIT_CONFIRM: begin
                // A correction on the final cycle cannot buy more time.
                if (i_correct && !w_expired) begin
                    w_state_nxt = WAIT_KEY;
                    w_code_nxt  = NULL_CODE;
                end else if (i_confirm) begin
                    w_state_nxt = EMIT;
                end else if (w_expired) begin
                    w_state_nxt = EMIT;
                    w_code_nxt  = NULL_CODE;
                end
            end
            EMIT: w_state_nxt = ACK;
            ACK: begin
                w_state_nxt = LOCKED;
                w_code_nxt  = NULL_CODE;
            end
            default: begin
                w_state_nxt = LOCKED;
                w_code_nxt  = NULL_CODE;
            end
        endcase
    end

    // Next output values.
    always_comb begin
        w_valid    = (w_state_nxt == EMIT);
        w_digit    = w_valid ? w_code_nxt : 4'd0;
        w_ready    = (w_state_nxt == WAIT_KEY) || (w_state_nxt == WAIT_CONFIRM);
        w_pending  = (w_state_nxt == WAIT_CONFIRM);
        w_shown    = w_pending ? w_code_nxt : 4'd0;
        w_done     = (r_state == ACK);
        w_accepted = w_done ? vote_bus.vote_status : r_accepted;
        w_votes    = w_done ? sat_inc(r_votes) : r_votes;
    end

    assign vote_bus.digit = r_digit;
    assign vote_bus.valid = r_valid;
    assign o_ready        = r_ready;
    assign o_pending      = r_pending;
    assign o_shown        = r_shown;
    assign o_done         = r_done;
    assign o_accepted     = r_accepted;
    assign o_votes_cast   = r_votes;

endmodule
